// File: rtl/dma_bus_master.sv
// Requester-side bus master for one DMA channel: copies a block of words src->dst
// as alternating read/write bus cycles while holding the arbiter request.
module dma_bus_master #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  size,
  output logic              m_req,
  input  logic              m_grant,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_wr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  size_q, size_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next-state and bus decode; bus outputs are gated by m_grant so an ungranted
  // cycle is a pure pause with nothing driven.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    size_d  = size_q;
    idx_d   = idx_q;
    data_d  = data_q;
    m_req   = 1'b0;
    m_addr  = '0;
    m_wr    = 1'b0;
    m_dout  = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          size_d  = size;
          idx_d   = '0;
          state_d = (size == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        m_req = 1'b1;
        busy  = 1'b1;
        if (m_grant) state_d = S_READ;
      end
      S_READ: begin
        m_req = 1'b1;
        busy  = 1'b1;
        if (m_grant) begin
          m_addr  = ADDR_W'(src_q + ADDR_W'(idx_q));
          data_d  = m_din;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        m_req = 1'b1;
        busy  = 1'b1;
        if (m_grant) begin
          m_addr = ADDR_W'(dst_q + ADDR_W'(idx_q));
          m_wr   = 1'b1;
          m_dout = data_q;
          if (idx_q == CNT_W'(size_q - CNT_W'(1))) begin
            state_d = S_DONE;
          end else begin
            idx_d   = CNT_W'(idx_q + CNT_W'(1));
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      size_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

endmodule
